// File: rtl/bf_tape_arbiter.sv
// bf_tape_arbiter: round-robin arbiter that shares the single-port, synchronous-read
// data-tape RAM between NREQ requesters (0 = interpreter core, 1 = program/input loader,
// 2 = display scanner).
//
// Optional feature macro: BF_ARB_LOCK_EN
//   When defined, a grant taken with lock[w]=1 keeps the RAM reserved for requester w
//   until it is granted again with lock[w]=0. This gives the core an atomic
//   read-modify-write for its +/- sequence. When undefined, lock is ignored.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   req, we, lock         per-requester request, write flag, lock-after-access flag
//   addr, wdata           per-requester address / write data, slice i = [i*W +: W]
//   gnt                   registered one-hot grant; a 1-cycle pulse issues the access
//   rvalid, rdata         one-hot read-return pulse the cycle after a read grant; data
//   mem_en/we/addr/wdata  RAM command, driven combinationally from the grant cycle
//   mem_rdata             RAM read data, valid the cycle after a read command
module bf_tape_arbiter #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned AW   = 8,
  parameter int unsigned DW   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      we,
  input  logic [NREQ*AW-1:0]   addr,
  input  logic [NREQ*DW-1:0]   wdata,
  input  logic [NREQ-1:0]      lock,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rvalid,
  output logic [DW-1:0]        rdata,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_wdata,
  input  logic [DW-1:0]        mem_rdata
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {
    ST_FREE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [PW-1:0]     owner;
  logic [PW-1:0]     owner_next;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     rr_ptr_next;
  logic [NREQ-1:0]   gnt_next;
  logic [NREQ-1:0]   eligible;
  logic              found;
  logic [PW-1:0]     win;

`ifndef BF_ARB_LOCK_EN
  logic unused_lock;
  assign unused_lock = ^lock;
`endif

  // State register: FSM state, owner, round-robin pointer, grant and read-return pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_FREE;
      owner  <= '0;
      rr_ptr <= PW'(NREQ - 1);
      gnt    <= '0;
      rvalid <= '0;
    end else begin
      state  <= state_next;
      owner  <= owner_next;
      rr_ptr <= rr_ptr_next;
      gnt    <= gnt_next;
      // we is stable while req is held, so it still describes the granted access here
      rvalid <= gnt & ~we;
    end
  end

  // Next-state: round-robin scan starting after rr_ptr, with explicit wrap for any NREQ.
  always_comb begin
    gnt_next    = '0;
    rr_ptr_next = rr_ptr;
    state_next  = state;
    owner_next  = owner;
    found       = 1'b0;
    win         = '0;

    // A requester granted this cycle is masked so it cannot win two cycles running.
    eligible = req & ~gnt;
`ifdef BF_ARB_LOCK_EN
    if (state == ST_LOCKED) begin
      eligible = eligible & (NREQ'(1) << owner);
    end
`endif

    for (int unsigned k = 1; k <= NREQ; k++) begin
      int unsigned idx;
      idx = 32'(rr_ptr) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (!found && eligible[PW'(idx)]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end

    if (found) begin
      gnt_next[win] = 1'b1;
      rr_ptr_next   = win;
`ifdef BF_ARB_LOCK_EN
      // The lock takes effect together with the grant, so the grant cycle is already held.
      if (lock[win]) begin
        state_next = ST_LOCKED;
        owner_next = win;
      end else begin
        state_next = ST_FREE;
      end
`endif
    end
  end

  // Output: RAM command muxed from the granted slice; all zero when nothing is granted.
  always_comb begin
    mem_en    = |gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        mem_we    = we[i];
        mem_addr  = addr[i*AW +: AW];
        mem_wdata = wdata[i*DW +: DW];
      end
    end
  end

  assign rdata = mem_rdata;

endmodule
